// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: data width, ALU op codes,
// RV32I opcode/funct fields and the operand-b source selector.
package alu_issue_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ALU_OP_W   = 6;

    // ALU op codes; zero is left unused so a reset output is never a real op
    localparam logic [ALU_OP_W-1:0] OP_ALU_ADD = 6'd1;
    localparam logic [ALU_OP_W-1:0] OP_ALU_SUB = 6'd2;
    localparam logic [ALU_OP_W-1:0] OP_ALU_AND = 6'd3;
    localparam logic [ALU_OP_W-1:0] OP_ALU_OR  = 6'd4;
    localparam logic [ALU_OP_W-1:0] OP_ALU_XOR = 6'd5;
    localparam logic [ALU_OP_W-1:0] OP_ALU_INV = 6'd6;
    localparam logic [ALU_OP_W-1:0] OP_ALU_SLT = 6'd7;
    localparam logic [ALU_OP_W-1:0] OP_ALU_SLL = 6'd8;
    localparam logic [ALU_OP_W-1:0] OP_ALU_SRL = 6'd9;
    localparam logic [ALU_OP_W-1:0] OP_ALU_SRA = 6'd10;

    // RV32I major opcodes handled here
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct3 encodings
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 encodings
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Where operand b comes from
    typedef enum logic [1:0] {
        B_RS2   = 2'd0,
        B_IMM   = 2'd1,
        B_SHAMT = 2'd2,
        B_ONES  = 2'd3
    } b_sel_e;

    // I-type immediate, sign-extended to the data width
    function automatic logic [DATA_WIDTH-1:0] imm_i(input logic [31:0] instr);
        return {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Two-read one-write register file with x0 hardwired to zero,
// writeback-to-read bypass and asynchronous clear.
module alu_regfile
    import alu_issue_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     rs1_addr,
    input  logic [ADDR_W-1:0]     rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    // Storage: clear everything on reset, never write x0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_en && (wb_rd != '0)) begin
            mem[wb_rd] <= wb_data;
        end
    end

    // Read ports: x0 reads zero, a same-cycle writeback is forwarded
    always_comb begin
        rs1_data = mem[rs1_addr];
        rs2_data = mem[rs2_addr];
        if (wb_en && (wb_rd == rs1_addr)) rs1_data = wb_data;
        if (wb_en && (wb_rd == rs2_addr)) rs2_data = wb_data;
        if (rs1_addr == '0) rs1_data = '0;
        if (rs2_addr == '0) rs2_data = '0;
    end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage in front of the ALU: decodes RV32I OP and OP-IMM,
// reads operands, tracks outstanding destinations in a scoreboard and
// hands the op to the ALU through a registered valid/ready output.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [31:0]           i_instr,
    output logic                  o_ready,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ALU_OP_W-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [ADDR_W-1:0]     o_rd,
    output logic                  o_illegal,
    input  logic                  i_wb_en,
    input  logic [ADDR_W-1:0]     i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_data
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [ADDR_W-1:0]     rd;
    logic [ADDR_W-1:0]     rs1;
    logic [ADDR_W-1:0]     rs2;

    logic                  dec_legal;
    logic                  dec_use_rs2;
    logic [ALU_OP_W-1:0]   dec_op;
    b_sel_e                dec_b_sel;

    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] operand_b;

    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;
    logic                  stall;
    logic                  accept;
    logic                  issue;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign funct7 = i_instr[31:25];

    alu_regfile #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_en    (i_wb_en),
        .wb_rd    (i_wb_rd),
        .wb_data  (i_wb_data)
    );

    // Instruction decode: op code, operand-b source and legality
    always_comb begin
        dec_legal   = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_op      = OP_ALU_ADD;
        dec_b_sel   = B_IMM;
        case (opcode)
            OPC_OP: begin
                dec_use_rs2 = 1'b1;
                dec_b_sel   = B_RS2;
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_ALU_ADD;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_ALU_SUB;
                        end
                    end
                    F3_SRL_SRA: begin
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_ALU_SRA;
                        end
                    end
                    F3_SLL: begin
                        dec_legal = (funct7 == F7_BASE);
                        dec_op    = OP_ALU_SLL;
                    end
                    F3_SLT: begin
                        dec_legal = (funct7 == F7_BASE);
                        dec_op    = OP_ALU_SLT;
                    end
                    F3_XOR: begin
                        dec_legal = (funct7 == F7_BASE);
                        dec_op    = OP_ALU_XOR;
                    end
                    F3_OR: begin
                        dec_legal = (funct7 == F7_BASE);
                        dec_op    = OP_ALU_OR;
                    end
                    F3_AND: begin
                        dec_legal = (funct7 == F7_BASE);
                        dec_op    = OP_ALU_AND;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_ALU_ADD;
                    end
                    F3_SLT: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_ALU_SLT;
                    end
                    F3_XOR: begin
                        dec_legal = 1'b1;
                        if (i_instr[31:20] == 12'hFFF) begin
                            dec_op    = OP_ALU_INV;
                            dec_b_sel = B_ONES;
                        end else begin
                            dec_op    = OP_ALU_XOR;
                        end
                    end
                    F3_OR: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_ALU_OR;
                    end
                    F3_AND: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_ALU_AND;
                    end
                    F3_SLL: begin
                        dec_legal = (funct7 == F7_BASE);
                        dec_op    = OP_ALU_SLL;
                        dec_b_sel = B_SHAMT;
                    end
                    F3_SRL_SRA: begin
                        dec_b_sel = B_SHAMT;
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_ALU_SRA;
                        end
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Operand b source mux
    always_comb begin
        operand_b = rs2_data;
        case (dec_b_sel)
            B_RS2:   operand_b = rs2_data;
            B_IMM:   operand_b = imm_i(i_instr);
            B_SHAMT: operand_b = {{(DATA_WIDTH-5){1'b0}}, i_instr[24:20]};
            B_ONES:  operand_b = '1;
            default: operand_b = rs2_data;
        endcase
    end

    // Hazard check: a pending source stalls unless its result arrives now
    always_comb begin
        stall = 1'b0;
        if (pending[rs1] && !(i_wb_en && (i_wb_rd == rs1))) stall = 1'b1;
        if (dec_use_rs2 && pending[rs2] && !(i_wb_en && (i_wb_rd == rs2))) stall = 1'b1;
    end

    assign o_ready = (!o_valid || i_ready) && !stall;
    assign accept  = i_valid && o_ready;
    assign issue   = accept && dec_legal;

    // Scoreboard update: writeback clears, issue sets and wins a tie
    always_comb begin
        pending_next = pending;
        if (i_wb_en) pending_next[i_wb_rd] = 1'b0;
        if (issue && (rd != '0)) pending_next[rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Output stage: load on issue, drain when consumed, hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid   <= 1'b0;
            o_illegal <= 1'b0;
            o_alu_op  <= '0;
            o_a       <= '0;
            o_b       <= '0;
            o_rd      <= '0;
        end else begin
            o_illegal <= accept && !dec_legal;
            if (issue) begin
                o_valid  <= 1'b1;
                o_alu_op <= dec_op;
                o_a      <= rs1_data;
                o_b      <= operand_b;
                o_rd     <= rd;
            end else if (i_ready) begin
                o_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue: a vector table for single-cycle
// decode plus hand-written hazard, backpressure and reset sequences.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_instr;
    logic        o_ready;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_alu_op;
    logic [31:0] o_a;
    logic [31:0] o_b;
    logic [4:0]  o_rd;
    logic        o_illegal;
    logic        i_wb_en;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        issue;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[$];

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_instr   (i_instr),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_alu_op  (o_alu_op),
        .o_a       (o_a),
        .o_b       (o_b),
        .o_rd      (o_rd),
        .o_illegal (o_illegal),
        .i_wb_en   (i_wb_en),
        .i_wb_rd   (i_wb_rd),
        .i_wb_data (i_wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr);
        @(negedge clk);
        i_valid = v;
        i_instr = instr;
    endtask

    task automatic writeBack(input logic [4:0] r, input logic [31:0] d);
        @(negedge clk);
        i_wb_en   = 1'b1;
        i_wb_rd   = r;
        i_wb_data = d;
        @(posedge clk);
        @(negedge clk);
        i_wb_en   = 1'b0;
    endtask

    task automatic addVec(input logic [31:0] instr, input logic issue, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        vec_t v;
        v.instr = instr; v.issue = issue; v.op = op; v.a = a; v.b = b; v.rd = rd;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_instr   = 32'h0;
        i_ready   = 1'b1;
        i_wb_en   = 1'b0;
        i_wb_rd   = 5'd0;
        i_wb_data = 32'h0;

        // Vector table: x1 = 0x00000101, x2 = 0x00010001
        addVec(32'h0020C1B3, 1'b1, OP_ALU_XOR, 32'h00000101, 32'h00010001, 5'd3);
        addVec(32'h402084B3, 1'b1, OP_ALU_SUB, 32'h00000101, 32'h00010001, 5'd9);
        addVec(32'h00209533, 1'b1, OP_ALU_SLL, 32'h00000101, 32'h00010001, 5'd10);
        addVec(32'h0020A5B3, 1'b1, OP_ALU_SLT, 32'h00000101, 32'h00010001, 5'd11);
        addVec(32'h0020D633, 1'b1, OP_ALU_SRL, 32'h00000101, 32'h00010001, 5'd12);
        addVec(32'h4020D6B3, 1'b1, OP_ALU_SRA, 32'h00000101, 32'h00010001, 5'd13);
        addVec(32'h0020E733, 1'b1, OP_ALU_OR,  32'h00000101, 32'h00010001, 5'd14);
        addVec(32'h0020F7B3, 1'b1, OP_ALU_AND, 32'h00000101, 32'h00010001, 5'd15);
        addVec(32'h022081B3, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0);
        addVec(32'h7FF0E813, 1'b1, OP_ALU_OR,  32'h00000101, 32'h000007FF, 5'd16);
        addVec(32'h80017893, 1'b1, OP_ALU_AND, 32'h00010001, 32'hFFFFF800, 5'd17);
        addVec(32'h0050A913, 1'b1, OP_ALU_SLT, 32'h00000101, 32'h00000005, 5'd18);
        addVec(32'h0F00C993, 1'b1, OP_ALU_XOR, 32'h00000101, 32'h000000F0, 5'd19);
        addVec(32'hFFF0C313, 1'b1, OP_ALU_INV, 32'h00000101, 32'hFFFFFFFF, 5'd6);
        addVec(32'h0020B3B3, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0);
        addVec(32'h00738B33, 1'b1, OP_ALU_ADD, 32'h00000000, 32'h00000000, 5'd22);
        addVec(32'h01F09A13, 1'b1, OP_ALU_SLL, 32'h00000101, 32'h0000001F, 5'd20);
        addVec(32'h40309B13, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0);
        addVec(32'h00415A93, 1'b1, OP_ALU_SRL, 32'h00010001, 32'h00000004, 5'd21);
        addVec(32'h0050BB93, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0);
        addVec(32'h000000B7, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0);
        addVec(32'h00000433, 1'b1, OP_ALU_ADD, 32'h00000000, 32'h00000000, 5'd8);

        // Reset state
        #1;
        checkOutput("rst.valid",   o_valid,   0);
        checkOutput("rst.illegal", o_illegal, 0);
        checkOutput("rst.op",      o_alu_op,  0);
        checkOutput("rst.a",       o_a,       0);
        checkOutput("rst.b",       o_b,       0);
        checkOutput("rst.rd",      o_rd,      0);
        checkOutput("rst.ready",   o_ready,   1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload, including a write to x0 that must be ignored
        writeBack(5'd1, 32'h00000101);
        writeBack(5'd2, 32'h00010001);
        writeBack(5'd0, 32'hDEADBEEF);

        $display("[TB] running %0d table vectors", vecs.size());
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(1'b1, vecs[k].instr);
            #1;
            checkOutput($sformatf("vec%0d.ready", k), o_ready, 1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d.valid", k),   o_valid,   vecs[k].issue);
            checkOutput($sformatf("vec%0d.illegal", k), o_illegal, !vecs[k].issue);
            if (vecs[k].issue) begin
                checkOutput($sformatf("vec%0d.op", k), o_alu_op, vecs[k].op);
                checkOutput($sformatf("vec%0d.a", k),  o_a,      vecs[k].a);
                checkOutput($sformatf("vec%0d.b", k),  o_b,      vecs[k].b);
                checkOutput($sformatf("vec%0d.rd", k), o_rd,     vecs[k].rd);
            end
        end
        applyStimulus(1'b0, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("idle.valid",   o_valid,   0);
        checkOutput("idle.illegal", o_illegal, 0);

        // RAW hazard: ADDI x4,x0,-16 then SRAI x5,x4,3 waits for x4 writeback
        applyStimulus(1'b1, 32'hFF000213);
        @(posedge clk);
        #1;
        checkOutput("addi.valid", o_valid,  1);
        checkOutput("addi.op",    o_alu_op, OP_ALU_ADD);
        checkOutput("addi.a",     o_a,      32'h0);
        checkOutput("addi.b",     o_b,      32'hFFFFFFF0);
        checkOutput("addi.rd",    o_rd,     5'd4);
        applyStimulus(1'b1, 32'h40325293);
        #1;
        checkOutput("raw.ready0", o_ready, 0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("raw.stall%0d.valid", c), o_valid, 0);
            checkOutput($sformatf("raw.stall%0d.ready", c), o_ready, 0);
        end
        @(negedge clk);
        i_wb_en   = 1'b1;
        i_wb_rd   = 5'd4;
        i_wb_data = 32'hFFFFFFF0;
        #1;
        checkOutput("raw.wb.ready", o_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("srai.valid", o_valid,  1);
        checkOutput("srai.op",    o_alu_op, OP_ALU_SRA);
        checkOutput("srai.a",     o_a,      32'hFFFFFFF0);
        checkOutput("srai.b",     o_b,      32'h3);
        checkOutput("srai.rd",    o_rd,     5'd5);
        @(negedge clk);
        i_wb_en = 1'b0;
        i_valid = 1'b0;
        @(posedge clk);

        // Backpressure: SUB x23 held for 3 cycles while OR x24 waits
        @(negedge clk);
        i_ready = 1'b0;
        applyStimulus(1'b1, 32'h40208BB3);
        @(posedge clk);
        applyStimulus(1'b1, 32'h0020EC33);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("bp%0d.valid", c), o_valid,  1);
            checkOutput($sformatf("bp%0d.op", c),    o_alu_op, OP_ALU_SUB);
            checkOutput($sformatf("bp%0d.a", c),     o_a,      32'h00000101);
            checkOutput($sformatf("bp%0d.b", c),     o_b,      32'h00010001);
            checkOutput($sformatf("bp%0d.rd", c),    o_rd,     5'd23);
            checkOutput($sformatf("bp%0d.ready", c), o_ready,  0);
            @(posedge clk);
        end
        @(negedge clk);
        i_ready = 1'b1;
        #1;
        checkOutput("bp.release.ready", o_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("bp.next.valid", o_valid,  1);
        checkOutput("bp.next.op",    o_alu_op, OP_ALU_OR);
        checkOutput("bp.next.rd",    o_rd,     5'd24);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp.nodup.valid", o_valid, 0);

        // Asynchronous reset in the middle of a stall
        @(negedge clk);
        i_ready = 1'b0;
        applyStimulus(1'b1, 32'h00208CB3);
        applyStimulus(1'b1, 32'h019C8D33);
        #1;
        checkOutput("rststall.ready_before", o_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rststall.valid", o_valid,  0);
        checkOutput("rststall.ready", o_ready,  1);
        checkOutput("rststall.op",    o_alu_op, 0);
        checkOutput("rststall.rd",    o_rd,     0);
        @(negedge clk);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        applyStimulus(1'b1, 32'h00208DB3);
        @(posedge clk);
        #1;
        checkOutput("postrst.valid", o_valid, 1);
        checkOutput("postrst.a",     o_a,     32'h0);
        checkOutput("postrst.b",     o_b,     32'h0);
        checkOutput("postrst.rd",    o_rd,    5'd27);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
